// File: rtl/fir_stream_driver_if.sv
// Stream/FIR handshake bundle for fir_stream_driver.
//   s_*      upstream sample port (valid/ready)
//   fir_*    serial FIR filter port (input/output valid pulses)
//   m_*      downstream result port (valid/ready)
// The master modport is the driver's view; slave is the environment's view.
interface fir_stream_driver_if #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned OUT_WIDTH = 38
);
  logic [WIDTH-1:0]     s_data;
  logic                 s_valid;
  logic                 s_ready;
  logic [WIDTH-1:0]     fir_in;
  logic                 fir_in_valid;
  logic [OUT_WIDTH-1:0] fir_out;
  logic                 fir_out_valid;
  logic [OUT_WIDTH-1:0] m_data;
  logic                 m_valid;
  logic                 m_ready;

  modport master (
    input  s_data, s_valid, fir_out, fir_out_valid, m_ready,
    output s_ready, fir_in, fir_in_valid, m_data, m_valid
  );

  modport slave (
    output s_data, s_valid, fir_out, fir_out_valid, m_ready,
    input  s_ready, fir_in, fir_in_valid, m_data, m_valid
  );
endinterface

// File: rtl/fir_stream_driver.sv
// Initiator-side driver for a serial FIR filter.
// Buffers upstream samples in a FIFO, issues one sample at a time to the FIR with a one-cycle
// fir_in_valid pulse, waits (with watchdog) for fir_out_valid, and presents the captured result
// downstream until accepted.
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   bus          fir_stream_driver_if.master (s_*, fir_*, m_* handshakes)
//   busy         FSM not idle
//   timeout_err  sticky watchdog error, cleared only by reset
//   fifo_count   entries currently buffered
module fir_stream_driver #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned OUT_WIDTH = 38,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  fir_stream_driver_if.master    bus,
  output logic                   busy,
  output logic                   timeout_err,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  localparam logic [PtrW:0]   FullCount  = DEPTH[PtrW:0];
  localparam logic [CntW-1:0] TimeoutVal = TIMEOUT[CntW-1:0];

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StHold} state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]    count_q, count_d;
  logic             s_ready;
  logic             push;
  logic             pop;

  logic [WIDTH-1:0]     fir_in_q, fir_in_d;
  logic [OUT_WIDTH-1:0] m_data_q, m_data_d;
  logic                 m_valid_q, m_valid_d;
  logic                 timeout_err_q, timeout_err_d;
  logic [CntW-1:0]      wait_cnt_q, wait_cnt_d;
  logic                 timed_out;

  // ---------------- FIFO ----------------
  assign s_ready   = (count_q < FullCount);
  assign push      = bus.s_valid && s_ready;
  // The head is popped on the same edge that moves IDLE -> ISSUE.
  assign pop       = (state_q == StIdle) && (count_q != '0);
  assign timed_out = (wait_cnt_q == TimeoutVal);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (PtrW+1)'(1);
      2'b01:   count_d = count_q - (PtrW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage needs no reset: only entries below count are ever read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.s_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= StIdle;
    else      state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (count_q != '0) state_d = StIssue;
      StIssue: state_d = StWait;
      // A result arriving on the timeout cycle takes priority over the abort.
      StWait: begin
        if (bus.fir_out_valid) state_d = StHold;
        else if (timed_out)    state_d = StIdle;
      end
      StHold:  if (m_valid_q && bus.m_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // ---------------- Datapath next state ----------------
  always_comb begin
    fir_in_d      = fir_in_q;
    m_data_d      = m_data_q;
    m_valid_d     = m_valid_q;
    timeout_err_d = timeout_err_q;
    wait_cnt_d    = wait_cnt_q;
    if (pop) fir_in_d = mem_q[rd_ptr_q];
    case (state_q)
      StIssue: wait_cnt_d = '0;
      StWait: begin
        if (bus.fir_out_valid) begin
          m_data_d  = bus.fir_out;
          m_valid_d = 1'b1;
        end else if (timed_out) begin
          timeout_err_d = 1'b1;
        end
        if (!timed_out) wait_cnt_d = wait_cnt_q + CntW'(1);
      end
      StHold:  if (m_valid_q && bus.m_ready) m_valid_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fir_in_q      <= '0;
      m_data_q      <= '0;
      m_valid_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      wait_cnt_q    <= '0;
    end else begin
      fir_in_q      <= fir_in_d;
      m_data_q      <= m_data_d;
      m_valid_q     <= m_valid_d;
      timeout_err_q <= timeout_err_d;
      wait_cnt_q    <= wait_cnt_d;
    end
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    bus.fir_in_valid = (state_q == StIssue);
    busy             = (state_q != StIdle);
    bus.fir_in       = fir_in_q;
    bus.m_data       = m_data_q;
    bus.m_valid      = m_valid_q;
    bus.s_ready      = s_ready;
    timeout_err      = timeout_err_q;
    fifo_count       = count_q;
  end

endmodule

// File: tb/tb_fir_stream_driver.sv
module tb_fir_stream_driver;

  logic       clk;
  logic       rst;
  logic       busy;
  logic       timeout_err;
  logic [3:0] fifo_count;
  int         vectors;
  int         miscompares;

  fir_stream_driver_if #(.WIDTH(16), .OUT_WIDTH(38)) bus ();

  fir_stream_driver #(
    .WIDTH(16), .OUT_WIDTH(38), .DEPTH(8), .TIMEOUT(255)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .busy       (busy),
    .timeout_err(timeout_err),
    .fifo_count (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic push_one(input logic [15:0] d);
    bus.s_data  = d;
    bus.s_valid = 1'b1;
    tick();
    bus.s_valid = 1'b0;
  endtask

  // Bounded search for the next fir_in_valid pulse.
  task automatic wait_issue(output bit found);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.fir_in_valid === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  // Called from the ISSUE cycle (or WAIT): answers the FIR, checks capture, completes handshake.
  task automatic respond(input logic [37:0] res, input string tag);
    tick();
    bus.fir_out       = res;
    bus.fir_out_valid = 1'b1;
    tick();
    bus.fir_out_valid = 1'b0;
    bus.fir_out       = ~res;
    vectors++;
    if (bus.m_valid !== 1'b1 || bus.m_data !== res) begin
      $display("FAIL %s capture: m_valid=%b m_data=%h, required 1 %h", tag, bus.m_valid,
               bus.m_data, res);
      miscompares++;
    end
    bus.m_ready = 1'b1;
    tick();
    bus.m_ready = 1'b0;
    vectors++;
    if (bus.m_valid !== 1'b0) begin
      $display("FAIL %s release: m_valid=%b, required 0", tag, bus.m_valid);
      miscompares++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #3;
    vectors++;
    if (bus.s_ready !== 1'b1 || fifo_count !== 4'd0) begin
      $display("FAIL reset_ready: s_ready=%b fifo_count=%0d, required 1 0", bus.s_ready,
               fifo_count);
      miscompares++;
    end
    vectors++;
    if ({bus.fir_in_valid, bus.m_valid, busy, timeout_err, bus.fir_in, bus.m_data} !== '0) begin
      $display("FAIL reset_zero: fiv=%b mv=%b busy=%b err=%b fir_in=%h m_data=%h, required all 0",
               bus.fir_in_valid, bus.m_valid, busy, timeout_err, bus.fir_in, bus.m_data);
      miscompares++;
    end
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_single();
    push_one(16'h0001);
    vectors++;
    if (bus.fir_in_valid !== 1'b0 || fifo_count !== 4'd1) begin
      $display("FAIL single_push: fiv=%b count=%0d, required 0 1", bus.fir_in_valid, fifo_count);
      miscompares++;
    end
    tick();
    vectors++;
    if (bus.fir_in_valid !== 1'b1 || bus.fir_in !== 16'h0001 || fifo_count !== 4'd0) begin
      $display("FAIL single_issue: fiv=%b fir_in=%h count=%0d, required 1 0001 0",
               bus.fir_in_valid, bus.fir_in, fifo_count);
      miscompares++;
    end
    tick();
    vectors++;
    if (bus.fir_in_valid !== 1'b0 || bus.fir_in !== 16'h0001 || busy !== 1'b1) begin
      $display("FAIL single_pulse: fiv=%b fir_in=%h busy=%b, required 0 0001 1",
               bus.fir_in_valid, bus.fir_in, busy);
      miscompares++;
    end
    repeat (48) tick();
    bus.fir_out       = 38'h1234;
    bus.fir_out_valid = 1'b1;
    tick();
    bus.fir_out_valid = 1'b0;
    bus.fir_out       = 38'h3F_FFFF_FFFF;
    repeat (5) tick();
    vectors++;
    if (bus.m_valid !== 1'b1 || bus.m_data !== 38'h1234) begin
      $display("FAIL single_hold: m_valid=%b m_data=%h, required 1 0000001234", bus.m_valid,
               bus.m_data);
      miscompares++;
    end
    bus.m_ready = 1'b1;
    tick();
    bus.m_ready = 1'b0;
    vectors++;
    if (bus.m_valid !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL single_done: m_valid=%b busy=%b, required 0 0", bus.m_valid, busy);
      miscompares++;
    end
  endtask

  task automatic test_burst();
    bit found;
    push_one(16'h0010);
    wait_issue(found);
    vectors++;
    if (!found || bus.fir_in !== 16'h0010) begin
      $display("FAIL burst_first: found=%b fir_in=%h, required 1 0010", found, bus.fir_in);
      miscompares++;
    end
    bus.s_valid = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      bus.s_data = 16'h0010 + 16'(i);
      tick();
    end
    vectors++;
    if (bus.s_ready !== 1'b0 || fifo_count !== 4'd8) begin
      $display("FAIL burst_full: s_ready=%b count=%0d, required 0 8", bus.s_ready, fifo_count);
      miscompares++;
    end
    bus.s_data = 16'h0019;
    tick();
    bus.s_valid = 1'b0;
    vectors++;
    if (fifo_count !== 4'd8) begin
      $display("FAIL burst_ninth: count=%0d, required 8", fifo_count);
      miscompares++;
    end
    respond({22'h2A5A5A, 16'h0010}, "burst0");
    for (int i = 1; i <= 8; i++) begin
      wait_issue(found);
      vectors++;
      if (!found || bus.fir_in !== 16'h0010 + 16'(i)) begin
        $display("FAIL burst_order%0d: found=%b fir_in=%h, required 1 %h", i, found, bus.fir_in,
                 16'h0010 + 16'(i));
        miscompares++;
      end
      respond({22'h2A5A5A, 16'h0010 + 16'(i)}, "burst");
    end
    wait_issue(found);
    vectors++;
    if (found || fifo_count !== 4'd0) begin
      $display("FAIL burst_drained: extra_issue=%b count=%0d, required 0 0", found, fifo_count);
      miscompares++;
    end
  endtask

  task automatic test_backpressure();
    bit found;
    push_one(16'h0055);
    wait_issue(found);
    bus.s_data  = 16'h0066;
    bus.s_valid = 1'b1;
    tick();
    bus.s_valid       = 1'b0;
    bus.fir_out       = 38'h00_0000_ABCD;
    bus.fir_out_valid = 1'b1;
    tick();
    bus.fir_out_valid = 1'b0;
    bus.fir_out       = 38'h11_1111_1111;
    for (int i = 0; i < 20; i++) begin
      vectors++;
      if (bus.m_valid !== 1'b1 || bus.m_data !== 38'h00_0000_ABCD ||
          bus.fir_in_valid !== 1'b0) begin
        $display("FAIL bp_hold%0d: m_valid=%b m_data=%h fiv=%b, required 1 000000abcd 0", i,
                 bus.m_valid, bus.m_data, bus.fir_in_valid);
        miscompares++;
      end
      tick();
    end
    bus.m_ready = 1'b1;
    tick();
    bus.m_ready = 1'b0;
    vectors++;
    if (bus.m_valid !== 1'b0 || bus.fir_in_valid !== 1'b0) begin
      $display("FAIL bp_handshake: m_valid=%b fiv=%b, required 0 0", bus.m_valid,
               bus.fir_in_valid);
      miscompares++;
    end
    tick();
    vectors++;
    if (bus.fir_in_valid !== 1'b1 || bus.fir_in !== 16'h0066) begin
      $display("FAIL bp_resume: fiv=%b fir_in=%h, required 1 0066", bus.fir_in_valid, bus.fir_in);
      miscompares++;
    end
    respond(38'h00_0000_0066, "bp_next");
  endtask

  task automatic test_back_to_back();
    bit found;
    do_reset();
    push_one(16'h0100);
    wait_issue(found);
    tick();
    bus.fir_out       = 38'h00_0000_0100;
    bus.fir_out_valid = 1'b1;
    tick();
    bus.fir_out_valid = 1'b0;
    bus.s_valid       = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      bus.s_data = 16'h0100 + 16'(i);
      tick();
    end
    bus.s_valid = 1'b0;
    vectors++;
    if (fifo_count !== 4'd7 || bus.m_valid !== 1'b1) begin
      $display("FAIL b2b_fill: count=%0d m_valid=%b, required 7 1", fifo_count, bus.m_valid);
      miscompares++;
    end
    bus.m_ready = 1'b1;
    tick();
    bus.m_ready = 1'b0;
    bus.s_data  = 16'h0108;
    bus.s_valid = 1'b1;
    tick();
    bus.s_valid = 1'b0;
    vectors++;
    if (fifo_count !== 4'd7 || bus.fir_in_valid !== 1'b1 || bus.fir_in !== 16'h0101) begin
      $display("FAIL b2b_pushpop: count=%0d fiv=%b fir_in=%h, required 7 1 0101", fifo_count,
               bus.fir_in_valid, bus.fir_in);
      miscompares++;
    end
    respond(38'h00_0000_0101, "b2b");
    for (int i = 2; i <= 8; i++) begin
      wait_issue(found);
      vectors++;
      if (!found || bus.fir_in !== 16'h0100 + 16'(i)) begin
        $display("FAIL b2b_order%0d: found=%b fir_in=%h, required 1 %h", i, found, bus.fir_in,
                 16'h0100 + 16'(i));
        miscompares++;
      end
      respond(38'h00_0000_0100 + 38'(i), "b2b");
    end
    vectors++;
    if (fifo_count !== 4'd0) begin
      $display("FAIL b2b_empty: count=%0d, required 0", fifo_count);
      miscompares++;
    end
  endtask

  task automatic test_timeout();
    bit found;
    do_reset();
    push_one(16'h0088);
    wait_issue(found);
    bus.s_valid = 1'b1;
    bus.s_data  = 16'h0077;
    tick();
    bus.s_data  = 16'h0066;
    tick();
    bus.s_valid = 1'b0;
    repeat (254) tick();
    // Now in the WAIT cycle whose counter equals TIMEOUT.
    vectors++;
    if (busy !== 1'b1 || timeout_err !== 1'b0 || bus.m_valid !== 1'b0) begin
      $display("FAIL to_edge_wait: busy=%b err=%b m_valid=%b, required 1 0 0", busy, timeout_err,
               bus.m_valid);
      miscompares++;
    end
    bus.fir_out       = 38'h00_0000_0099;
    bus.fir_out_valid = 1'b1;
    tick();
    bus.fir_out_valid = 1'b0;
    vectors++;
    if (bus.m_valid !== 1'b1 || bus.m_data !== 38'h99 || timeout_err !== 1'b0) begin
      $display("FAIL to_edge_capture: m_valid=%b m_data=%h err=%b, required 1 0000000099 0",
               bus.m_valid, bus.m_data, timeout_err);
      miscompares++;
    end
    bus.m_ready = 1'b1;
    tick();
    bus.m_ready = 1'b0;
    wait_issue(found);
    vectors++;
    if (!found || bus.fir_in !== 16'h0077) begin
      $display("FAIL to_second: found=%b fir_in=%h, required 1 0077", found, bus.fir_in);
      miscompares++;
    end
    repeat (256) tick();
    vectors++;
    if (busy !== 1'b1 || timeout_err !== 1'b0) begin
      $display("FAIL to_early: busy=%b err=%b, required 1 0", busy, timeout_err);
      miscompares++;
    end
    tick();
    vectors++;
    if (busy !== 1'b0 || timeout_err !== 1'b1 || bus.m_valid !== 1'b0) begin
      $display("FAIL to_abort: busy=%b err=%b m_valid=%b, required 0 1 0", busy, timeout_err,
               bus.m_valid);
      miscompares++;
    end
    tick();
    vectors++;
    if (bus.fir_in_valid !== 1'b1 || bus.fir_in !== 16'h0066) begin
      $display("FAIL to_next: fiv=%b fir_in=%h, required 1 0066", bus.fir_in_valid, bus.fir_in);
      miscompares++;
    end
    respond(38'h15_5555_5555, "to_next");
    vectors++;
    if (timeout_err !== 1'b1) begin
      $display("FAIL to_sticky: err=%b, required 1", timeout_err);
      miscompares++;
    end
  endtask

  task automatic test_reset_mid();
    bit found;
    do_reset();
    push_one(16'h0001);
    wait_issue(found);
    bus.s_valid = 1'b1;
    for (int i = 2; i <= 4; i++) begin
      bus.s_data = 16'(i);
      tick();
    end
    bus.s_valid = 1'b0;
    vectors++;
    if (fifo_count !== 4'd3 || busy !== 1'b1) begin
      $display("FAIL mid_setup: count=%0d busy=%b, required 3 1", fifo_count, busy);
      miscompares++;
    end
    #2;
    rst = 1'b0;
    #1;
    vectors++;
    if (bus.s_ready !== 1'b1 || fifo_count !== 4'd0 ||
        {bus.fir_in_valid, bus.m_valid, busy, timeout_err, bus.fir_in, bus.m_data} !== '0) begin
      $display("FAIL mid_reset: s_ready=%b count=%0d fiv=%b mv=%b busy=%b err=%b fir_in=%h, %s",
               bus.s_ready, fifo_count, bus.fir_in_valid, bus.m_valid, busy, timeout_err,
               bus.fir_in, "required 1 0 and all else 0");
      miscompares++;
    end
    tick();
    rst = 1'b1;
    bus.fir_out       = 38'h2A_AAAA_AAAA;
    bus.fir_out_valid = 1'b1;
    tick();
    bus.fir_out_valid = 1'b0;
    wait_issue(found);
    vectors++;
    if (found || bus.m_valid !== 1'b0 || busy !== 1'b0 || fifo_count !== 4'd0) begin
      $display("FAIL mid_late: issue=%b m_valid=%b busy=%b count=%0d, required 0 0 0 0", found,
               bus.m_valid, busy, fifo_count);
      miscompares++;
    end
  endtask

  initial begin
    vectors           = 0;
    miscompares       = 0;
    rst               = 1'b0;
    bus.s_data        = '0;
    bus.s_valid       = 1'b0;
    bus.fir_out       = '0;
    bus.fir_out_valid = 1'b0;
    bus.m_ready       = 1'b0;
    test_reset();
    test_single();
    test_burst();
    test_backpressure();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
